// File: rtl/csum_sched_pkg.sv
// csum_pkg: shared types for the IPv4 header checksum scheduler.
//   CSUM_HDR_BYTES : bytes in an IPv4 header without options
//   state_t        : scheduler FSM states
//   hdr_t          : header as a byte array, index 0 = first byte on the wire
//   req_id_t       : requester id (0 = TX header builder, 1 = RX header checker)
package csum_pkg;

  localparam int CSUM_HDR_BYTES = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef logic [CSUM_HDR_BYTES-1:0][7:0] hdr_t;

  typedef logic req_id_t;

  // One-hot per-requester vector for a requester id.
  function automatic logic [1:0] req_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/csum_sched_if.sv
// csum_sched_if: request/response bundle between the two header requesters
// and the checksum scheduler.
//   req_valid_i : per-requester request valid (requester -> scheduler)
//   req_ready_o : per-requester accept, at most one bit set
//   req0_hdr_i  : header from requester 0
//   req1_hdr_i  : header from requester 1
//   rsp_valid_o : per-requester response valid, at most one bit set
//   rsp_ready_i : per-requester response accept
//   rsp_csum_o  : checksum result shared by both requesters
//   rsp_ok_o    : result is 16'h0000 (header verified good)
// master = requester side, slave = scheduler side.
interface csum_sched_if;
  import csum_pkg::*;

  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  hdr_t        req0_hdr_i;
  hdr_t        req1_hdr_i;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready_i;
  logic [15:0] rsp_csum_o;
  logic        rsp_ok_o;

  modport master (
    output req_valid_i, req0_hdr_i, req1_hdr_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_csum_o, rsp_ok_o
  );

  modport slave (
    input  req_valid_i, req0_hdr_i, req1_hdr_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_csum_o, rsp_ok_o
  );

endinterface

// File: rtl/csum_sched.sv
// csum_sched: shares one IPv4 header checksum engine between requester 0
// (TX header builder) and requester 1 (RX header checker). A granted header
// is latched and held on the engine inputs for the full engine latency,
// because the engine stages are not latency-aligned and cannot be streamed.
// The result is then captured and returned on a valid/ready response port.
//   CLK_i        : clock, rising edge
//   RSTn_i       : asynchronous active-low reset
//   bus          : request/response bundle (csum_sched_if.slave)
//   err_cnt_o    : saturating count of accepted responses with rsp_ok_o = 0
//   eng_data_o   : header presented to the engine (held between operations)
//   eng_dataen_o : engine enable, high only while the engine is running
//   eng_csum_i   : engine result, valid ENGINE_LAT cycles after stable inputs
module csum_sched
  import csum_pkg::*;
#(
  parameter int ENGINE_LAT = 4
) (
  input  logic          CLK_i,
  input  logic          RSTn_i,
  csum_sched_if.slave   bus,
  output logic [15:0]   err_cnt_o,
  output hdr_t          eng_data_o,
  output logic          eng_dataen_o,
  input  logic [15:0]   eng_csum_i
);

  localparam int                CNT_W    = $clog2(ENGINE_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ENGINE_LAT);

  state_t            state;
  req_id_t           pri;
  req_id_t           owner;
  logic [CNT_W-1:0]  cnt;
  hdr_t              hdr_q;
  logic [15:0]       csum_q;
  logic              ok_q;
  logic [15:0]       err_cnt;
  logic              dataen_q;
  logic [1:0]        rsp_vld_q;

  logic              grant_vld;
  req_id_t           grant_id;

  // Round-robin grant: on contention the requester at pri wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (&bus.req_valid_i) begin
      grant_vld = 1'b1;
      grant_id  = pri;
    end else if (bus.req_valid_i[0]) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (bus.req_valid_i[1]) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
  end

  // req_ready is combinational from req_valid; gating with RSTn_i keeps it
  // low while reset is held, even if a requester is already asserting valid.
  assign bus.req_ready_o = (state == IDLE && grant_vld && RSTn_i) ?
                           req_onehot(grant_id) : 2'b00;

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state     <= IDLE;
      pri       <= 1'b0;
      owner     <= 1'b0;
      cnt       <= '0;
      hdr_q     <= '0;
      csum_q    <= '0;
      ok_q      <= 1'b0;
      err_cnt   <= '0;
      dataen_q  <= 1'b0;
      rsp_vld_q <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            hdr_q    <= grant_id ? bus.req1_hdr_i : bus.req0_hdr_i;
            owner    <= grant_id;
            cnt      <= '0;
            dataen_q <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // hdr_q has been stable on the engine for ENGINE_LAT cycles here.
          if (cnt == CNT_LAST) begin
            csum_q    <= eng_csum_i;
            ok_q      <= (eng_csum_i == 16'h0000);
            dataen_q  <= 1'b0;
            rsp_vld_q <= req_onehot(owner);
            state     <= RSP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RSP: begin
          if (bus.rsp_ready_i[owner]) begin
            pri       <= ~owner;
            rsp_vld_q <= 2'b00;
            if (!ok_q && err_cnt != 16'hFFFF) begin
              err_cnt <= err_cnt + 16'd1;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid_o = rsp_vld_q;
  assign bus.rsp_csum_o  = (state == RSP) ? csum_q : 16'h0000;
  assign bus.rsp_ok_o    = (state == RSP) ? ok_q   : 1'b0;
  assign err_cnt_o       = err_cnt;
  assign eng_data_o      = hdr_q;
  assign eng_dataen_o    = dataen_q;

endmodule
